dds_voice_mixer: RTL

DDS_VOICE_MIXER -- requirements
Module: dds_voice_mixer

---
 rtl/dds_voice_mixer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dds_voice_mixer.sv
// Multi-channel DDS voice mixer: per-channel pulse/noise oscillators time-sliced
// over a frame counter, summed with saturation into one signed sample per frame.
module dds_voice_mixer #(
    parameter int NUM_CH       = 4,
    parameter int ACC_W        = 16,
    parameter int VOL_W        = 8,
    parameter int OUT_W        = 16,
    parameter int FRAME_CYCLES = 1024,
    localparam int CH_W        = $clog2(NUM_CH),
    localparam int ADDR_W      = CH_W + 2
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [15:0]       data_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              data_valid_in,
    output logic [OUT_W-1:0]  data_out,
    output logic              data_valid_out
);

    localparam int FC_W = $clog2(FRAME_CYCLES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_N    = FC_W'(NUM_CH);
    localparam logic [FC_W-1:0] FC_CLR  = FC_W'(2 * NUM_CH - 1);
    localparam logic [FC_W-1:0] FC_2N   = FC_W'(2 * NUM_CH);
    localparam logic [FC_W-1:0] FC_3N   = FC_W'(3 * NUM_CH);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
    localparam logic [3:0]      GS_MAX  = 4'(CH_W);
    localparam logic [OUT_W-1:0] MIX_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIX_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [FC_W-1:0]  fc_q, fc_d;
    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [ACC_W-1:0] acc_d [NUM_CH];
    logic [ACC_W-1:0] incr_q [NUM_CH];
    logic [ACC_W-1:0] incr_d [NUM_CH];
    logic [VOL_W-1:0] vol_q [NUM_CH];
    logic [VOL_W-1:0] vol_d [NUM_CH];
    logic [3:0]       ctrl_q [NUM_CH];
    logic [3:0]       ctrl_d [NUM_CH];
    logic [14:0]      lfsr_q [NUM_CH];
    logic [14:0]      lfsr_d [NUM_CH];
    logic [NUM_CH-1:0] wbit_q, wbit_d;
    logic [3:0]       gain_q, gain_d;
    logic [OUT_W-1:0] mix_q, mix_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic             data_valid_out_q, data_valid_out_d;

    logic [1:0]       wr_bank;
    logic [CH_W-1:0]  wr_ch;
    logic [CH_W-1:0]  sel_ch;
    logic [ACC_W:0]   acc_sum;
    logic [OUT_W-1:0] sample;
    logic [OUT_W-1:0] contrib;

    // Register writes: data_valid_in is a plain strobe, accepted on every clock
    // edge it is high; there is no ready/backpressure path.
    assign wr_bank = addr_in[ADDR_W-1:CH_W];
    assign wr_ch   = addr_in[CH_W-1:0];
    // Every slot region starts on a multiple of NUM_CH, so the low fc bits name the channel.
    assign sel_ch  = fc_q[CH_W-1:0];

    function automatic logic [OUT_W-1:0] amp_of(input logic [VOL_W-1:0] v);
        logic [OUT_W-1:0] a;
        a = '0;
        for (int i = 0; i < OUT_W - 1; i++) begin
            a[OUT_W-2-i] = v[VOL_W-1-(i % VOL_W)];
        end
        return a;
    endfunction

    function automatic logic wave_bit(input logic [2:0] wave, input logic [2:0] top3,
                                      input logic noise);
        case (wave)
            3'd1:    return top3 == 3'd7;
            3'd2:    return top3 >= 3'd6;
            3'd3:    return top3 >= 3'd5;
            3'd4:    return noise;
            default: return top3[2];
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] sat_add(input logic [OUT_W-1:0] a,
                                                 input logic [OUT_W-1:0] b);
        logic [OUT_W:0] s;
        s = {a[OUT_W-1], a} + {b[OUT_W-1], b};
        if (s[OUT_W] != s[OUT_W-1]) begin
            return s[OUT_W] ? MIX_MIN : MIX_MAX;
        end
        return s[OUT_W-1:0];
    endfunction

    always_comb begin
        fc_d             = (fc_q == FC_LAST) ? '0 : fc_q + FC_ONE;
        acc_d            = acc_q;
        incr_d           = incr_q;
        vol_d            = vol_q;
        ctrl_d           = ctrl_q;
        lfsr_d           = lfsr_q;
        wbit_d           = wbit_q;
        gain_d           = gain_q;
        mix_d            = mix_q;
        data_out_d       = data_out_q;
        data_valid_out_d = 1'b0;

        acc_sum = {1'b0, acc_q[sel_ch]} + {1'b0, incr_q[sel_ch]};
        sample  = wbit_q[sel_ch] ? amp_of(vol_q[sel_ch]) : ~amp_of(vol_q[sel_ch]);
        contrib = ctrl_q[sel_ch][3] ? OUT_W'($signed(sample) >>> gain_q) : '0;

        if (fc_q < FC_N) begin
            acc_d[sel_ch] = acc_sum[ACC_W-1:0];
            if (acc_sum[ACC_W]) begin
                lfsr_d[sel_ch] = {lfsr_q[sel_ch][13:0], lfsr_q[sel_ch][14] ^ lfsr_q[sel_ch][13]};
            end
        end
        if (fc_q >= FC_N && fc_q < FC_2N) begin
            wbit_d[sel_ch] = wave_bit(ctrl_q[sel_ch][2:0], acc_q[sel_ch][ACC_W-1 -: 3],
                                      lfsr_q[sel_ch][0]);
        end
        if (fc_q == FC_CLR) begin
            mix_d = '0;
        end
        if (fc_q >= FC_2N && fc_q < FC_3N) begin
            mix_d = sat_add(mix_q, contrib);
        end
        if (fc_q == FC_3N) begin
            data_out_d       = mix_q;
            data_valid_out_d = 1'b1;
        end

        // Writes come last so a phase-reset strobe wins over this slot's accumulate.
        if (data_valid_in) begin
            case (wr_bank)
                2'd0: incr_d[wr_ch] = data_in[ACC_W-1:0];
                2'd1: vol_d[wr_ch]  = data_in[VOL_W-1:0];
                2'd2: begin
                    ctrl_d[wr_ch] = data_in[3:0];
                    if (data_in[4]) begin
                        acc_d[wr_ch]  = '0;
                        lfsr_d[wr_ch] = 15'h7FFF;
                    end
                end
                default: begin
                    if (wr_ch == '0) begin
                        gain_d = (data_in[3:0] > GS_MAX) ? GS_MAX : data_in[3:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            fc_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                incr_q[i] <= '0;
                vol_q[i]  <= '0;
                ctrl_q[i] <= '0;
                lfsr_q[i] <= 15'h7FFF;
            end
            wbit_q           <= '0;
            gain_q           <= GS_MAX;
            mix_q            <= '0;
            data_out_q       <= '0;
            data_valid_out_q <= 1'b0;
        end else begin
            fc_q             <= fc_d;
            acc_q            <= acc_d;
            incr_q           <= incr_d;
            vol_q            <= vol_d;
            ctrl_q           <= ctrl_d;
            lfsr_q           <= lfsr_d;
            wbit_q           <= wbit_d;
            gain_q           <= gain_d;
            mix_q            <= mix_d;
            data_out_q       <= data_out_d;
            data_valid_out_q <= data_valid_out_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_valid_out = data_valid_out_q;

endmodule
